// File: rtl/layer_output_collector_if.sv
// rtl/layer_output_collector_if.sv - neuron capture, serial stream and result signals of the collector
interface layer_output_collector_if #(
    parameter int num_neurons = 10,
    parameter int data_width  = 16
);
    localparam int idx_width = $clog2(num_neurons);

    logic [num_neurons*data_width-1:0] n_out;
    logic [num_neurons-1:0]            n_valid;
    logic [data_width-1:0]             s_data;
    logic                              s_valid;
    logic                              s_ready;
    logic                              s_last;
    logic [idx_width-1:0]              argmax_idx;
    logic [data_width-1:0]             max_value;
    logic                              result_valid;
    logic                              busy;
    logic                              drop_err;

    // master: the collector itself; slave: producing layer plus next-layer consumer
    modport master (
        input  n_out, n_valid, s_ready,
        output s_data, s_valid, s_last, argmax_idx, max_value, result_valid, busy, drop_err
    );

    modport slave (
        output n_out, n_valid, s_ready,
        input  s_data, s_valid, s_last, argmax_idx, max_value, result_valid, busy, drop_err
    );
endinterface

// File: rtl/layer_output_collector.sv
// rtl/layer_output_collector.sv - captures one activation per neuron, finds the argmax, re-streams the vector
module layer_output_collector #(
    parameter int  num_neurons = 10,
    parameter int  data_width  = 16,
    localparam int idx_width   = $clog2(num_neurons)
) (
    input  logic                     clk,
    input  logic                     rst,
    layer_output_collector_if.master bus
);
    typedef enum logic [1:0] {COLLECT, SCAN, STREAM} state_t;

    localparam logic [idx_width-1:0] last_idx = idx_width'(num_neurons - 1);

    state_t                  state, state_next;
    logic [num_neurons-1:0]  captured;
    logic [num_neurons-1:0]  new_capture;
    logic [data_width-1:0]   buf_mem [num_neurons];
    logic [idx_width-1:0]    scan_k;
    logic [idx_width-1:0]    rd_ptr;
    logic [data_width-1:0]   best_val, cand_val;
    logic [idx_width-1:0]    best_idx, cand_idx;
    logic [idx_width-1:0]    argmax_idx_r;
    logic [data_width-1:0]   max_value_r;
    logic                    result_valid_r;
    logic                    drop_err_r;
    logic                    busy_w;
    logic                    hs;
    logic                    hs_last;

    always_comb begin
        new_capture = '0;
        if (state == COLLECT)
            new_capture = bus.n_valid & ~captured;
        busy_w  = (state == SCAN) || (state == STREAM);
        hs      = (state == STREAM) && bus.s_ready;
        hs_last = hs && (rd_ptr == last_idx);

        // strict greater-than keeps the lowest index on ties
        cand_val = best_val;
        cand_idx = best_idx;
        if (scan_k == '0 || $signed(buf_mem[scan_k]) > $signed(best_val)) begin
            cand_val = buf_mem[scan_k];
            cand_idx = scan_k;
        end

        state_next = state;
        case (state)
            COLLECT: if (&(captured | new_capture)) state_next = SCAN;
            SCAN:    if (scan_k == last_idx)        state_next = STREAM;
            STREAM:  if (hs_last)                   state_next = COLLECT;
            default:                                state_next = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= COLLECT;
        else
            state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            captured       <= '0;
            for (int i = 0; i < num_neurons; i++)
                buf_mem[i] <= '0;
            scan_k         <= '0;
            rd_ptr         <= '0;
            best_val       <= '0;
            best_idx       <= '0;
            argmax_idx_r   <= '0;
            max_value_r    <= '0;
            result_valid_r <= 1'b0;
            drop_err_r     <= 1'b0;
        end else begin
            result_valid_r <= hs_last;
            if (busy_w && (|bus.n_valid))
                drop_err_r <= 1'b1;

            for (int i = 0; i < num_neurons; i++) begin
                if (new_capture[i]) begin
                    buf_mem[i]  <= bus.n_out[i*data_width +: data_width];
                    captured[i] <= 1'b1;
                end
            end

            if (state == SCAN) begin
                best_val <= cand_val;
                best_idx <= cand_idx;
                if (scan_k == last_idx) begin
                    scan_k       <= '0;
                    argmax_idx_r <= cand_idx;
                    max_value_r  <= cand_val;
                end else begin
                    scan_k <= scan_k + idx_width'(1);
                end
            end

            if (hs) begin
                if (hs_last) begin
                    rd_ptr   <= '0;
                    captured <= '0;
                end else begin
                    rd_ptr <= rd_ptr + idx_width'(1);
                end
            end
        end
    end

    assign bus.s_valid      = (state == STREAM);
    assign bus.s_data       = buf_mem[rd_ptr];
    assign bus.s_last       = (state == STREAM) && (rd_ptr == last_idx);
    assign bus.argmax_idx   = argmax_idx_r;
    assign bus.max_value    = max_value_r;
    assign bus.result_valid = result_valid_r;
    assign bus.busy         = busy_w;
    assign bus.drop_err     = drop_err_r;
endmodule

// File: tb/tb_layer_output_collector.sv
// tb/tb_layer_output_collector.sv - scoreboard bench for layer_output_collector with a 4-neuron layer
module tb_layer_output_collector;
    localparam int N  = 4;
    localparam int W  = 16;
    localparam int IW = $clog2(N);

    typedef logic [W-1:0] vec_t [N];
    typedef struct packed {logic [W-1:0] data; logic last;} beat_t;
    typedef struct packed {logic [IW-1:0] idx; logic [W-1:0] val;} res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    layer_output_collector_if #(.num_neurons(N), .data_width(W)) bus();
    layer_output_collector #(.num_neurons(N), .data_width(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int     tests = 0;
    int     fails = 0;
    int     hs_count = 0;
    int     n_results = 0;
    beat_t  exp_beats[$];
    res_t   exp_res[$];
    logic   rdy_pat[$];
    logic   rdy_rand = 1'b0;
    logic   rdy_default = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        tests++;
        fails++;
        $display("FAIL %s: event did not occur as required", name);
    endtask

    function automatic logic [N*W-1:0] pack(input vec_t v);
        logic [N*W-1:0] p;
        for (int i = 0; i < N; i++) p[i*W +: W] = v[i];
        return p;
    endfunction

    // reference: largest signed value first, then the lowest index holding it
    function automatic void issue_expect(input vec_t v);
        beat_t b;
        res_t r;
        logic [W-1:0] mx;
        int idx;
        for (int i = 0; i < N; i++) begin
            b.data = v[i];
            b.last = (i == N-1);
            exp_beats.push_back(b);
        end
        mx = v[0];
        for (int i = 1; i < N; i++) if ($signed(v[i]) > $signed(mx)) mx = v[i];
        idx = 0;
        for (int i = N-1; i >= 0; i--) if (v[i] == mx) idx = i;
        r.idx = IW'(idx);
        r.val = mx;
        exp_res.push_back(r);
    endfunction

    task automatic strobe(input logic [N-1:0] mask, input logic [N*W-1:0] data);
        bus.n_valid = mask;
        bus.n_out   = data;
        @(posedge clk);
        #1;
        bus.n_valid = '0;
    endtask

    task automatic send_seq(input vec_t v);
        for (int i = 0; i < N; i++) strobe(N'(1) << i, pack(v));
    endtask

    task automatic send_rand(input vec_t v);
        logic [N-1:0] cap, m, d;
        logic [N*W-1:0] data;
        cap = '0;
        while (cap != '1) begin
            m = N'($urandom) & ~cap;
            if (m == '0)
                for (int i = 0; i < N; i++) if (!cap[i] && m == '0) m[i] = 1'b1;
            d = N'($urandom) & cap;
            for (int i = 0; i < N; i++) data[i*W +: W] = m[i] ? v[i] : W'($urandom);
            strobe(m | d, data);
            cap = cap | m;
        end
    endtask

    task automatic wait_result(input int base);
        int t;
        t = 0;
        while (n_results <= base && t < 300) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (n_results <= base) fail_now("result_timeout");
    endtask

    task automatic wait_valid();
        int t;
        t = 0;
        while (!bus.s_valid && t < 60) begin
            @(negedge clk);
            t++;
        end
        if (!bus.s_valid) fail_now("valid_timeout");
    endtask

    task automatic run_vec(input vec_t v, input int mode);
        int base;
        base = n_results;
        issue_expect(v);
        case (mode)
            0:       send_seq(v);
            1:       strobe('1, pack(v));
            default: send_rand(v);
        endcase
        wait_result(base);
    endtask

    initial begin
        bus.s_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_pat.size() > 0) bus.s_ready = rdy_pat.pop_front();
            else if (rdy_rand)      bus.s_ready = 1'($urandom_range(0, 1));
            else                    bus.s_ready = rdy_default;
        end
    end

    // monitor: pops expectations on every handshake and result pulse, and polices stalls
    initial begin
        logic prev_stall;
        logic [W-1:0] prev_data;
        beat_t b;
        res_t r;
        prev_stall = 1'b0;
        prev_data  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("stall_valid", 32'(bus.s_valid), 32'd1);
                    check("stall_data", 32'(bus.s_data), 32'(prev_data));
                end
                if (bus.s_valid && bus.s_ready) begin
                    hs_count++;
                    if (exp_beats.size() == 0) fail_now("beat_unexpected");
                    else begin
                        b = exp_beats.pop_front();
                        check("s_data", 32'(bus.s_data), 32'(b.data));
                        check("s_last", 32'(bus.s_last), 32'(b.last));
                    end
                end
                if (bus.result_valid) begin
                    n_results++;
                    if (exp_res.size() == 0) fail_now("result_unexpected");
                    else begin
                        r = exp_res.pop_front();
                        check("argmax_idx", 32'(bus.argmax_idx), 32'(r.idx));
                        check("max_value", 32'(bus.max_value), 32'(r.val));
                    end
                end
                prev_stall = bus.s_valid && !bus.s_ready;
                prev_data  = bus.s_data;
            end
        end
    end

    initial begin
        #3000000;
        fail_now("global_timeout");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "timeout");
    end

    initial begin
        vec_t v;
        int   base, c, n, hs0;
        bus.n_valid = '0;
        bus.n_out   = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_s_valid", 32'(bus.s_valid), 32'd0);
        check("rst_s_last", 32'(bus.s_last), 32'd0);
        check("rst_s_data", 32'(bus.s_data), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_argmax", 32'(bus.argmax_idx), 32'd0);
        check("rst_max", 32'(bus.max_value), 32'd0);
        check("rst_result", 32'(bus.result_valid), 32'd0);
        check("rst_drop", 32'(bus.drop_err), 32'd0);

        // individual strobes, latency and stream timing
        v = '{16'h0100, 16'h0800, 16'h0300, 16'h0050};
        base = n_results;
        issue_expect(v);
        for (int i = 0; i < N; i++) begin
            strobe(N'(1) << i, pack(v));
            if (i < N-1) check("busy_collect", 32'(bus.busy), 32'd0);
        end
        @(negedge clk);
        check("busy_rise", 32'(bus.busy), 32'd1);
        c = 1;
        while (!bus.s_valid && c < 40) begin
            @(negedge clk);
            c++;
        end
        check("first_valid_latency", 32'(c), 32'(N+1));
        n = 0;
        while (bus.s_valid && n < 40) begin
            n++;
            @(negedge clk);
        end
        check("stream_cycles", 32'(n), 32'(N));
        check("valid_after_last", 32'(bus.s_valid), 32'd0);
        check("result_pulse", 32'(bus.result_valid), 32'd1);
        @(negedge clk);
        check("result_one_cycle", 32'(bus.result_valid), 32'd0);
        wait_result(base);
        check("t1_argmax", 32'(bus.argmax_idx), 32'd1);
        check("t1_max", 32'(bus.max_value), 32'h0800);
        check("t1_drop", 32'(bus.drop_err), 32'd0);

        // tie and signed comparisons
        v = '{16'h0200, 16'h0200, 16'h0200, 16'h0200};
        run_vec(v, 1);
        check("tie_argmax", 32'(bus.argmax_idx), 32'd0);
        check("tie_max", 32'(bus.max_value), 32'h0200);
        v = '{16'h8000, 16'hFFFF, 16'h0000, 16'h7FFF};
        run_vec(v, 1);
        check("signed_a", 32'(bus.argmax_idx), 32'd3);
        v = '{16'h8000, 16'hFFFF, 16'h8001, 16'h9000};
        run_vec(v, 0);
        check("signed_b", 32'(bus.argmax_idx), 32'd1);

        // backpressure pattern
        rdy_default = 1'b0;
        v = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        base = n_results;
        issue_expect(v);
        strobe('1, pack(v));
        wait_valid();
        hs0 = hs_count;
        rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        wait_result(base);
        check("bp_handshakes", 32'(hs_count - hs0), 32'd4);
        rdy_pat.delete();
        rdy_default = 1'b1;

        // duplicate strobe keeps the first value
        v = '{16'h0111, 16'h0222, 16'h0010, 16'h0333};
        base = n_results;
        issue_expect(v);
        strobe(4'b0100, pack(v));
        v[2] = 16'h0FFF;
        strobe(4'b0100, pack(v));
        strobe(4'b1011, pack(v));
        wait_result(base);
        check("dup_drop", 32'(bus.drop_err), 32'd0);
        check("dup_argmax", 32'(bus.argmax_idx), 32'd3);

        // strobe during stream
        rdy_default = 1'b0;
        v = '{16'h0A00, 16'hF000, 16'h0B00, 16'h0001};
        base = n_results;
        issue_expect(v);
        strobe('1, pack(v));
        wait_valid();
        strobe(4'b0001, {N{16'h7777}});
        check("drop_set", 32'(bus.drop_err), 32'd1);
        rdy_default = 1'b1;
        wait_result(base);
        check("drop_sticky", 32'(bus.drop_err), 32'd1);

        // reset after two handshakes
        v = '{16'h0005, 16'h0006, 16'h0007, 16'h0008};
        issue_expect(v);
        strobe('1, pack(v));
        hs0 = hs_count;
        c = 0;
        while (hs_count < hs0 + 2 && c < 60) begin
            @(posedge clk);
            #2;
            c++;
        end
        if (hs_count < hs0 + 2) fail_now("pre_reset_handshakes");
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        exp_beats.delete();
        exp_res.delete();
        @(negedge clk);
        check("mid_rst_valid", 32'(bus.s_valid), 32'd0);
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_argmax", 32'(bus.argmax_idx), 32'd0);
        check("mid_rst_drop", 32'(bus.drop_err), 32'd0);
        v = '{16'h0042, 16'h0041, 16'h0043, 16'h0040};
        run_vec(v, 0);
        check("post_rst_argmax", 32'(bus.argmax_idx), 32'd2);

        // random back-to-back vectors with random backpressure
        rdy_rand = 1'b1;
        for (int k = 0; k < 10; k++) begin
            for (int i = 0; i < N; i++) begin
                case ($urandom_range(0, 5))
                    0:       v[i] = 16'h8000;
                    1:       v[i] = 16'h7FFF;
                    2:       v[i] = 16'h0300;
                    default: v[i] = W'($urandom);
                endcase
            end
            run_vec(v, $urandom_range(0, 2));
        end
        rdy_rand = 1'b0;

        repeat (5) @(negedge clk);
        check("beats_left", 32'(exp_beats.size()), 32'd0);
        check("results_left", 32'(exp_res.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/layer_output_collector.md
Name: layer_output_collector

Overview:
- Sits at the consumer end of the neuron output interface (`out` / `valid_out`) of a layer of `num_neurons` parallel neurons.
- Captures one activation per neuron and scans the captured vector for the argmax.
- Re-serialises the vector as a valid/ready stream that feeds the next layer's input load, then reports the classification result.

Parameters:
- `num_neurons`, 10, number of neurons in the producing layer (≥2).
- `data_width`, 16, width of one activation (signed fixed point).
- `idx_width`, `$clog2(num_neurons)`, width of neuron index; derived, do not override.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `n_out`  in  `num_neurons*data_width`  packed neuron outputs; neuron i at bits [i*data_width +: data_width].
- `n_valid`  in  `num_neurons`  per-neuron output-valid strobes.
- `s_data`  out  `data_width`  serial activation to next layer.
- `s_valid`  out  1  `s_data` valid.
- `s_ready`  in  1  downstream accepts `s_data`.
- `s_last`  out  1  high with the final element (index `num_neurons-1`).
- `argmax_idx`  out  `idx_width`  index of the largest activation.
- `max_value`  out  `data_width`  value at `argmax_idx`.
- `result_valid`  out  1  one-cycle pulse when a vector has been fully streamed.
- `busy`  out  1  high in SCAN or STREAM.
- `drop_err`  out  1  sticky; a strobe arrived while not collecting.

Behaviour:
- Reset (synchronous, `rst` high at an edge):
  - all outputs go to 0;
  - the captured mask and buffer are cleared;
  - state becomes COLLECT;
  - `rst` overrides any operation mid-flight, and a partial vector is discarded.
- States: COLLECT → SCAN → STREAM → COLLECT.
- COLLECT:
  - At each edge, for every i with `n_valid[i]`=1 and `captured[i]`=0: store `n_out` slice i into `buf[i]` and set `captured[i]`.
  - First strobe wins; repeat strobes for an already captured neuron are ignored silently (no `drop_err`).
  - Multiple neurons may capture in the same cycle.
  - When the mask, including captures made at this edge, becomes all-ones, the next state is SCAN.
- SCAN:
  - Exactly `num_neurons` cycles, with scan index k=0..N-1, one element per cycle.
  - k=0 loads `best_val=buf[0]`, `best_idx=0`.
  - For k>0, update only if `$signed(buf[k]) > $signed(best_val)`. This is strict, so ties resolve to the lowest index.
  - After k=N-1, `argmax_idx`/`max_value` update from `best` and then hold until the next vector's SCAN completes. Next state is STREAM.
- STREAM:
  - `s_valid`=1 and `s_data=buf[rd_ptr]`; `rd_ptr` starts at 0.
  - On `s_valid && s_ready`, `rd_ptr` increments.
  - `s_data` / `s_valid` must hold stable while `s_ready`=0.
  - `s_last = (rd_ptr == N-1)`.
  - The handshake on the last element causes all of the following at that edge:
    - next state is COLLECT;
    - `captured` is cleared;
    - `rd_ptr` goes to 0;
    - `result_valid` is 1 for the following cycle only.
  - `s_valid` is 0 in the cycle after the last handshake.
- `busy` = (state==SCAN || state==STREAM).
- Any `n_valid` bit high while `busy`:
  - the value is not stored;
  - `drop_err` is set and stays set until `rst`.
- Capture in COLLECT in the same cycle as the `result_valid` pulse is legal and counts toward the new vector.
- Latency:
  - the last capture edge is followed by N SCAN cycles;
  - first `s_valid` appears N+1 cycles after the last capture edge;
  - with `s_ready` held high, the stream occupies N cycles.
- Buffer contents are unchanged from capture until overwritten by the next COLLECT.

Test Plan:
- N=4, `data_width`=16:
  - Stimulus: strobe neurons 0..3 individually on separate cycles with values 0x0100, 0x0800, 0x0300, 0x0050, `s_ready`=1.
  - Required response: `busy` rises the cycle after the 4th capture; `argmax_idx`=1, `max_value`=0x0800; stream emits 0x0100, 0x0800, 0x0300, 0x0050 on consecutive cycles with `s_last` on the 4th; `result_valid` pulses once.
- Tie: all four values 0x0200 strobed in one cycle → `argmax_idx`=0, `max_value`=0x0200.
- Signed compare: values 0x8000, 0xFFFF, 0x0000, 0x7FFF → `argmax_idx`=3. Then values 0x8000, 0xFFFF, 0x8001, 0x9000 → `argmax_idx`=1.
- Backpressure: with `s_ready` toggling 1,0,0,1,0,1,1 → `s_data` is held stable during stalls; exactly 4 handshakes occur in order; no element is duplicated or skipped.
- Duplicate and drop:
  - Strobe neuron 2 with 0x0010, then again with 0x0FFF before the others → `buf[2]` stays 0x0010; `drop_err` stays 0.
  - Strobe neuron 0 during STREAM → `drop_err`=1 and it persists; the streamed data is unaffected.
- Reset mid-STREAM: assert `rst` after 2 handshakes → next cycle `s_valid`=0, `busy`=0, `argmax_idx`=0, `drop_err`=0; a following full 4-neuron capture streams correctly from index 0.
